// File: rtl/mem_write_buffer.sv
// In-order store buffer: queues CPU stores and drains them to memory over a
// write/ack handshake, forwarding buffered data to younger loads.
module mem_write_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_hit,
   output logic [DATA_W-1:0] ld_data,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {StIdle, StWrite} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic push, pop;

   assign full      = (count_q == CW'(DEPTH));
   assign st_ready  = ~full;
   assign empty     = (count_q == '0) && (state_q == StIdle);
   assign push      = st_valid && st_ready;
   // The head entry leaves the FIFO only once memory acknowledges it.
   assign pop       = (state_q == StWrite) && mem_ack;
   assign mem_wr_en = wr_en_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= st_addr;
         data_mem[wr_ptr_q] <= st_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      wr_en_d = wr_en_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               addr_d  = addr_mem[rd_ptr_q];
               wdata_d = data_mem[rd_ptr_q];
               wr_en_d = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (mem_ack) begin
               wr_en_d = 1'b0;
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Scan oldest to youngest so the youngest match overrides earlier ones.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      ld_hit  = 1'b0;
      ld_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_mem[idx] == ld_addr)) begin
            ld_hit  = 1'b1;
            ld_data = data_mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: reset, drain timing, full/backpressure,
// forwarding, same-edge push/pop, pointer wrap and ack-while-idle.
module tb_mem_write_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid, st_ready;
   logic [15:0] st_addr, st_data;
   logic        mem_wr_en;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [15:0] ld_addr;
   logic        ld_hit;
   logic [15:0] ld_data;
   logic        empty, full;

   int tests = 0;
   int fails = 0;

   mem_write_buffer #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data),
      .empty     (empty),
      .full      (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [15:0] a, input logic [15:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      step();
      st_valid = 1'b0;
   endtask

   task automatic wait_wr();
      int n = 0;
      while (mem_wr_en !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("wr_wait_timeout", 32'(n < 20), 32'd1);
   endtask

   task automatic ack_expect(input logic [15:0] a, input logic [15:0] d);
      wait_wr();
      chk("drain_addr", 32'(mem_addr), 32'(a));
      chk("drain_data", 32'(mem_wdata), 32'(d));
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
      mem_ack = 1'b0; ld_addr = '0;
      #2;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Single store, ack 3 cycles after mem_wr_en rises.
      push_store(16'h0010, 16'hBEEF);
      chk("t2_no_bypass", 32'(mem_wr_en), 32'd0);
      chk("t2_not_empty", 32'(empty), 32'd0);
      step();
      chk("t2_wr_en", 32'(mem_wr_en), 32'd1);
      chk("t2_addr", 32'(mem_addr), 32'h0010);
      chk("t2_data", 32'(mem_wdata), 32'hBEEF);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("t2_hold_en", 32'(mem_wr_en), 32'd1);
         chk("t2_hold_addr", 32'(mem_addr), 32'h0010);
         chk("t2_hold_data", 32'(mem_wdata), 32'hBEEF);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("t2_wr_en_drop", 32'(mem_wr_en), 32'd0);
      chk("t2_empty", 32'(empty), 32'd1);

      // Five back-to-back stores with no ack: only four fit.
      for (int k = 0; k < 4; k++) push_store(16'h0100 + 16'(k), 16'hA000 + 16'(k));
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_ready", 32'(st_ready), 32'd0);
      push_store(16'h0104, 16'hA004);
      chk("t3_still_full", 32'(full), 32'd1);
      for (int k = 0; k < 4; k++) ack_expect(16'h0100 + 16'(k), 16'hA000 + 16'(k));
      chk("t3_drained", 32'(empty), 32'd1);

      // Forwarding: youngest match wins; same-cycle push not yet visible.
      ld_addr  = 16'h0020;
      st_valid = 1'b1; st_addr = 16'h0020; st_data = 16'h1111;
      #1;
      chk("t4_push_invisible", 32'(ld_hit), 32'd0);
      step();
      push_store(16'h0020, 16'h2222);
      chk("t4_hit", 32'(ld_hit), 32'd1);
      chk("t4_youngest", 32'(ld_data), 32'h2222);
      ld_addr = 16'h0030;
      #1;
      chk("t4_miss", 32'(ld_hit), 32'd0);
      chk("t4_miss_data", 32'(ld_data), 32'd0);
      ack_expect(16'h0020, 16'h1111);
      ld_addr = 16'h0020;
      #1;
      chk("t4_younger_left", 32'(ld_data), 32'h2222);
      ack_expect(16'h0020, 16'h2222);
      #1;
      chk("t4_gone", 32'(ld_hit), 32'd0);

      // Full buffer with store and ack on the same edge.
      for (int k = 0; k < 4; k++) push_store(16'h0300 + 16'(k), 16'hB000 + 16'(k));
      wait_wr();
      chk("t5_full", 32'(full), 32'd1);
      st_valid = 1'b1; st_addr = 16'h0304; st_data = 16'hB004; mem_ack = 1'b1;
      #1;
      chk("t5_ready_low", 32'(st_ready), 32'd0);
      step();
      mem_ack = 1'b0;
      chk("t5_after_pop", 32'(full), 32'd0);
      chk("t5_ready_high", 32'(st_ready), 32'd1);
      step();
      st_valid = 1'b0;
      chk("t5_refull", 32'(full), 32'd1);
      for (int k = 1; k < 5; k++) ack_expect(16'h0300 + 16'(k), 16'hB000 + 16'(k));
      chk("t5_empty", 32'(empty), 32'd1);

      // Stream 3*DEPTH stores through the buffer with immediate acks.
      begin
         int pushed = 0;
         int acked  = 0;
         int cyc    = 0;
         while ((pushed < 12 || acked < 12) && cyc < 300) begin
            mem_ack  = 1'b0;
            st_valid = 1'b0;
            if (mem_wr_en) begin
               chk("wrap_addr", 32'(mem_addr), 32'h0200 + 32'(acked));
               chk("wrap_data", 32'(mem_wdata), 32'(16'hC000 + 16'(acked * 257)));
               mem_ack = 1'b1;
               acked++;
            end
            if (pushed < 12 && st_ready) begin
               st_valid = 1'b1;
               st_addr  = 16'h0200 + 16'(pushed);
               st_data  = 16'hC000 + 16'(pushed * 257);
               pushed++;
            end
            step();
            cyc++;
         end
         mem_ack  = 1'b0;
         st_valid = 1'b0;
         chk("wrap_count", 32'(acked), 32'd12);
         chk("wrap_empty", 32'(empty), 32'd1);
      end

      // Ack while IDLE with an entry pending must not pop it.
      push_store(16'h0040, 16'h4444);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("t6_wr_en", 32'(mem_wr_en), 32'd1);
      chk("t6_not_empty", 32'(empty), 32'd0);
      ld_addr = 16'h0040;
      #1;
      chk("t6_entry_kept", 32'(ld_hit), 32'd1);
      step();
      chk("t6_still_writing", 32'(mem_wr_en), 32'd1);
      ack_expect(16'h0040, 16'h4444);
      chk("t6_empty", 32'(empty), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("t6_idle_ack", 32'(mem_wr_en), 32'd0);

      // Asynchronous reset in the middle of a write.
      push_store(16'h0050, 16'h5555);
      push_store(16'h0051, 16'h5556);
      wait_wr();
      rst_n = 1'b0;
      #1;
      chk("t1_wr_en", 32'(mem_wr_en), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_ready", 32'(st_ready), 32'd1);
      chk("t1_addr", 32'(mem_addr), 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();
      chk("t1_discarded", 32'(mem_wr_en), 32'd0);
      chk("t1_stay_empty", 32'(empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
